// File: rtl/vending_pkg.sv
// Shared types and helpers for the vending machine credit controller.
package vending_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COLLECT  = 2'd1,
      ST_DISPENSE = 2'd2,
      ST_CHANGE   = 2'd3
   } state_t;

   localparam logic [1:0] COIN_5C  = 2'b00;
   localparam logic [1:0] COIN_10C = 2'b01;
   localparam logic [1:0] COIN_25C = 2'b10;
   localparam logic [1:0] COIN_INV = 2'b11;

   // Coin code to credit units (5c each); the invalid code is worth nothing.
   function automatic logic [3:0] coin_value(input logic [1:0] code);
      logic [3:0] val;
      case (code)
         COIN_5C:  val = 4'd1;
         COIN_10C: val = 4'd2;
         COIN_25C: val = 4'd5;
         default:  val = 4'd0;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/vending_ctrl.sv
// Sequencing controller for the vending credit datapath; it is the only writer
// of the external sum register and reads its value back on i_sum.
module vending_ctrl
   import vending_pkg::*;
#(
   parameter int PRICE = 4
) (
   input  logic       i_clk,
   input  logic       i_sum_rst,
   input  logic       i_coin_valid,
   input  logic [1:0] i_coin_type,
   input  logic       i_cancel,
   input  logic       i_change_ack,
   input  logic [3:0] i_sum,
   output logic       o_sum_ld,
   output logic [3:0] o_sum_next,
   output logic       o_dispense,
   output logic       o_change_valid,
   output logic [3:0] o_change,
   output logic       o_coin_rej,
   output logic       o_busy,
   output logic [7:0] o_sales
);

   generate
      if (PRICE < 1 || PRICE > 10) begin : g_price_chk
         $error("vending_ctrl: PRICE must be within 1..10");
      end
   endgenerate

   localparam logic [3:0] PRICE_U = 4'(PRICE);

   state_t     state_r;
   state_t     state_next_s;
   logic       coin_ok_s;
   logic [3:0] credit_new_s;

   // PRICE range keeps the 4-bit sum from overflowing.
   assign coin_ok_s    = i_coin_valid && (i_coin_type != COIN_INV);
   assign credit_new_s = i_sum + coin_value(i_coin_type);

   assign o_dispense     = (state_r == ST_DISPENSE);
   assign o_change_valid = (state_r == ST_CHANGE);
   assign o_busy         = (state_r == ST_DISPENSE) || (state_r == ST_CHANGE);
   assign o_change       = o_change_valid ? i_sum : 4'd0;

   // State register.
   always_ff @(posedge i_clk or negedge i_sum_rst) begin
      if (!i_sum_rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Completed-vend counter; wraps naturally at 8 bits.
   always_ff @(posedge i_clk or negedge i_sum_rst) begin
      if (!i_sum_rst) begin
         o_sales <= 8'd0;
      end else if (state_r == ST_DISPENSE) begin
         o_sales <= o_sales + 8'd1;
      end else begin
         o_sales <= o_sales;
      end
   end

   // Next state, sum-register load and coin rejection.
   always_comb begin
      state_next_s = state_r;
      o_sum_ld     = 1'b0;
      o_sum_next   = 4'd0;
      o_coin_rej   = 1'b0;
      case (state_r)
         ST_IDLE, ST_COLLECT: begin
            o_coin_rej = i_coin_valid && (i_coin_type == COIN_INV);
            // A coin beats a simultaneous cancel.
            if (coin_ok_s) begin
               o_sum_ld   = 1'b1;
               o_sum_next = credit_new_s;
               if (credit_new_s >= PRICE_U) begin
                  state_next_s = ST_DISPENSE;
               end else begin
                  state_next_s = ST_COLLECT;
               end
            end else if (i_cancel && (state_r == ST_COLLECT)) begin
               state_next_s = ST_CHANGE;
            end else begin
               state_next_s = state_r;
            end
         end
         ST_DISPENSE: begin
            o_coin_rej = i_coin_valid;
            o_sum_ld   = 1'b1;
            o_sum_next = i_sum - PRICE_U;
            if (i_sum != PRICE_U) begin
               state_next_s = ST_CHANGE;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_CHANGE: begin
            o_coin_rej = i_coin_valid;
            if (i_change_ack) begin
               o_sum_ld     = 1'b1;
               o_sum_next   = 4'd0;
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_CHANGE;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

endmodule

// File: doc/vending_ctrl.md
# vending_ctrl

Sequencing controller for the vending machine's 4-bit credit datapath. It accepts coin events, computes the next credit value and drives the load port of the external sum register, whose output it reads back. It dispenses when credit reaches the item price, hands out change over a valid/ack handshake, and supports a refund on cancel. It sits beside the sum register in the vending machine top level and is the only block that writes the register.

## Interface
- PRICE, default 4: item price in 5c units; legal range 1..10, so credit never exceeds 15.
- i_clk  in  1  clock; rising-edge.
- i_sum_rst  in  1  reset, asynchronous, active-low; shared with the sum register.
- i_coin_valid  in  1  one-cycle coin event.
- i_coin_type  in  2  coin code: 00 = 5c (1 unit), 01 = 10c (2 units), 10 = 25c (5 units), 11 = invalid.
- i_cancel  in  1  refund request.
- i_change_ack  in  1  change consumer has taken o_change.
- i_sum  in  4  current credit, read back from the sum register output.
- o_sum_ld  out  1  load enable to the sum register.
- o_sum_next  out  4  data to the sum register.
- o_dispense  out  1  one-cycle vend pulse.
- o_change_valid  out  1  change amount is presented.
- o_change  out  4  change amount in units; equals i_sum while o_change_valid = 1, 0 otherwise.
- o_coin_rej  out  1  coin event was not accepted.
- o_busy  out  1  high in DISPENSE or CHANGE.
- o_sales  out  8  count of completed vends; wraps 255→0.

## Operation
- States are IDLE, COLLECT, DISPENSE, CHANGE. Reset state is IDLE.
- Coin value v comes from i_coin_type. The candidate credit is new = i_sum + v, computed at 4 bits with no overflow because of the PRICE range.
- **IDLE or COLLECT, valid coin:**
  - o_sum_ld = 1 and o_sum_next = new.
  - If new ≥ PRICE, go to DISPENSE; otherwise go to COLLECT.
- **Cancel versus coin:** in COLLECT, i_cancel without a coin goes to CHANGE with no load. If i_cancel and i_coin_valid are both high, the coin wins and cancel is ignored that cycle.
- **Cancel in IDLE:** ignored.
- **DISPENSE (exactly one cycle):**
  - o_dispense = 1, o_sum_ld = 1, o_sum_next = i_sum − PRICE.
  - o_sales increments.
  - Go to CHANGE if the remainder is non-zero; otherwise go to IDLE.
- **CHANGE:**
  - o_change_valid = 1 and o_change = i_sum; both hold stable until acknowledged.
  - On i_change_ack, drive o_sum_ld = 1, o_sum_next = 0, and go to IDLE.
  - i_change_ack outside CHANGE is ignored.
- **Coin rejection:** o_coin_rej = i_coin_valid AND (i_coin_type = 11 OR state is DISPENSE or CHANGE). A rejected coin causes no load and no state change.
- **Idle drive:** o_sum_ld = 0 and o_sum_next = 0 in every case not listed above.

## Timing
- Only the state register and o_sales are flops. o_sum_ld, o_sum_next, o_coin_rej and o_change are combinational from state and inputs, so each register load lands on the same edge as the state transition.
- Credit latency: a coin sampled at edge N is visible on i_sum after edge N; the DISPENSE decision uses the value computed in cycle N.
- The coin-to-vend pulse takes 1 cycle: a coin that reaches PRICE at edge N gives o_dispense high during cycle N+1.
- The change handshake has no timeout and stays in CHANGE indefinitely.
- Reset values: state IDLE, o_sales 0, and every output 0.
- Assertion of i_sum_rst mid-transaction clears the controller and the sum register together. Accumulated credit is lost by design.

## Structure
- vending_pkg holds:
  - the state enum (state_t, 2 bits);
  - the coin code localparams;
  - a function coin_value(code) returning 4-bit units.
- No sub-module inside vending_ctrl. The top level instantiates vending_ctrl and the sum register side by side and connects:
  - o_sum_ld → i_sum_ld
  - o_sum_next → i_sum
  - o_sum → i_sum
- An elaboration-time check rejects PRICE outside 1..10.

## Test plan
- Exact price, PRICE = 4: insert coins 10c, 10c → i_sum goes 2 then 4; o_dispense pulses once; state returns to IDLE with i_sum = 0; o_sales = 1; o_change_valid never asserts.
- Overpay: insert 25c from IDLE → DISPENSE, then o_change_valid with o_change = 1. Hold ack low for 5 cycles → o_change stays 1. Raise ack → i_sum = 0 and state returns to IDLE.
- Cancel: insert 5c, 10c (i_sum = 3), then i_cancel → o_change = 3; after ack, i_sum = 0. A simultaneous coin and cancel in COLLECT loads the coin and stays in COLLECT.
- Rejects: coin code 11 in IDLE, and any coin while busy, each give a one-cycle o_coin_rej pulse with i_sum unchanged.
- Reset mid-change: assert i_sum_rst while in CHANGE → all outputs 0 asynchronously; after release, state is IDLE and i_sum = 0.
- Wrap: 256 exact-price vends → o_sales wraps to 0.
